// File: rtl/data_mem_responder.sv
// Data-memory responder for the 9-bit CPU: 256-byte store with single-cycle
// stores and fixed-latency loads, raising busy while a load is outstanding.
module data_mem_responder #(
   parameter int unsigned READ_LAT = 2,
   parameter int unsigned DEPTH    = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       loadEn,
   input  logic       storEn,
   input  logic [7:0] addr,
   input  logic [7:0] storData,
   output logic [7:0] loadData,
   output logic       done,
   output logic       busy,
   output logic       err
);

   typedef enum logic {
      IDLE,
      LOAD_WAIT
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

   state_t     state_q, state_d;
   logic [1:0] lat_cnt_q, lat_cnt_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] load_data_q, load_data_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       mem_we;

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lat_cnt_q   <= '0;
         addr_q      <= '0;
         load_data_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         addr_q      <= addr_d;
         load_data_q <= load_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Array has no reset so its contents survive a mid-load reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr] <= storData;
      end
   end

   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      addr_d      = addr_q;
      load_data_d = load_data_q;
      done_d      = 1'b0;
      err_d       = err_q;
      mem_we      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (storEn) begin
               // A store wins over a simultaneous load; the load is dropped.
               mem_we = 1'b1;
               done_d = 1'b1;
               if (loadEn) begin
                  err_d = 1'b1;
               end
            end else if (loadEn) begin
               addr_d    = addr;
               lat_cnt_d = LAT_INIT;
               state_d   = LOAD_WAIT;
            end
         end
         LOAD_WAIT: begin
            if (lat_cnt_q != 2'd0) begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end else begin
               load_data_d = mem_q[addr_q];
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign loadData = load_data_q;
   assign done     = done_q;
   assign busy     = (state_q == LOAD_WAIT);
   assign err      = err_q;

endmodule
